// File: rtl/ddr_page_sequencer.sv
// Page-transaction sequencer that shares one DdrCtl1 instruction port between two requesters.
// Each access issues address, data and command instructions, then waits for ddr_ready and acks.
module ddr_page_sequencer #(
  parameter int         TIMEOUT = 4096,
  parameter logic [3:0] OP_NOP  = 4'd0,
  parameter logic [3:0] OP_LA0  = 4'd1,
  parameter logic [3:0] OP_LA1  = 4'd2,
  parameter logic [3:0] OP_LA2  = 4'd3,
  parameter logic [3:0] OP_LA3  = 4'd4,
  parameter logic [3:0] OP_LD0  = 4'd5,
  parameter logic [3:0] OP_LD1  = 4'd6,
  parameter logic [3:0] OP_LD2  = 4'd7,
  parameter logic [3:0] OP_LD3  = 4'd8,
  parameter logic [3:0] OP_RDP  = 4'd9,
  parameter logic [3:0] OP_WRP  = 4'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic        we_a,
  input  logic [31:0] addr_a,
  input  logic [31:0] wdata_a,
  output logic        ack_a,
  output logic [31:0] rdata_a,
  input  logic        req_b,
  input  logic        we_b,
  input  logic [31:0] addr_b,
  input  logic [31:0] wdata_b,
  output logic        ack_b,
  output logic [31:0] rdata_b,
  output logic [11:0] ddr_inst,
  output logic        ddr_inst_en,
  input  logic [31:0] ddr_page,
  input  logic        ddr_ready,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, CMD, HOLD, WAIT, RESP} state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t      state;
  logic [1:0]  idx;
  logic        sel;        // 1 = requester b owns the current transaction
  logic        rr;         // 1 = b wins the next tie
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] last_addr;
  logic        last_valid;
  logic [15:0] wdog;

  logic        grant_b;
  logic        g_we;
  logic        g_hit;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    byte_sel = w[{k, 3'b000} +: 8];
  endfunction

  function automatic logic [3:0] la_op(input logic [1:0] k);
    case (k)
      2'd0:    la_op = OP_LA0;
      2'd1:    la_op = OP_LA1;
      2'd2:    la_op = OP_LA2;
      default: la_op = OP_LA3;
    endcase
  endfunction

  function automatic logic [3:0] ld_op(input logic [1:0] k);
    case (k)
      2'd0:    ld_op = OP_LD0;
      2'd1:    ld_op = OP_LD1;
      2'd2:    ld_op = OP_LD2;
      default: ld_op = OP_LD3;
    endcase
  endfunction

  always_comb begin
    grant_b = req_b && (!req_a || rr);
    g_we    = grant_b ? we_b    : we_a;
    g_addr  = grant_b ? addr_b  : addr_a;
    g_wdata = grant_b ? wdata_b : wdata_a;
    g_hit   = last_valid && (g_addr == last_addr);
  end

  assign busy = (state != IDLE);

  // Instruction outputs are loaded on the edge that enters an issuing state, so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 2'd0;
      sel         <= 1'b0;
      rr          <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= 32'h0;
      wdata_reg   <= 32'h0;
      last_addr   <= 32'h0;
      last_valid  <= 1'b0;
      wdog        <= 16'h0;
      ddr_inst    <= {OP_NOP, 8'h00};
      ddr_inst_en <= 1'b0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      rdata_a     <= 32'h0;
      rdata_b     <= 32'h0;
      error       <= 1'b0;
    end else begin
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      ddr_inst    <= {OP_NOP, 8'h00};
      ddr_inst_en <= 1'b0;
      case (state)
        IDLE: begin
          if (ddr_ready && (req_a || req_b)) begin
            sel         <= grant_b;
            rr          <= ~grant_b;
            we_reg      <= g_we;
            addr_reg    <= g_addr;
            wdata_reg   <= g_wdata;
            idx         <= 2'd0;
            ddr_inst_en <= 1'b1;
            if (!g_hit) begin
              state    <= ADDR;
              ddr_inst <= {OP_LA0, g_addr[7:0]};
            end else if (g_we) begin
              state    <= DATA;
              ddr_inst <= {OP_LD0, g_wdata[7:0]};
            end else begin
              state    <= CMD;
              ddr_inst <= {OP_RDP, 8'h00};
            end
          end
        end
        ADDR: begin
          ddr_inst_en <= 1'b1;
          if (idx == 2'd3) begin
            idx        <= 2'd0;
            last_addr  <= addr_reg;
            last_valid <= 1'b1;
            if (we_reg) begin
              state    <= DATA;
              ddr_inst <= {OP_LD0, wdata_reg[7:0]};
            end else begin
              state    <= CMD;
              ddr_inst <= {OP_RDP, 8'h00};
            end
          end else begin
            idx      <= idx + 2'd1;
            ddr_inst <= {la_op(idx + 2'd1), byte_sel(addr_reg, idx + 2'd1)};
          end
        end
        DATA: begin
          ddr_inst_en <= 1'b1;
          if (idx == 2'd3) begin
            idx      <= 2'd0;
            state    <= CMD;
            ddr_inst <= {OP_WRP, 8'h00};
          end else begin
            idx      <= idx + 2'd1;
            ddr_inst <= {ld_op(idx + 2'd1), byte_sel(wdata_reg, idx + 2'd1)};
          end
        end
        CMD: begin
          state <= HOLD;
          wdog  <= 16'h0;
        end
        HOLD: state <= WAIT;
        WAIT: begin
          if (ddr_ready) begin
            state <= RESP;
            ack_a <= ~sel;
            ack_b <= sel;
            if (!we_reg) begin
              if (sel) rdata_b <= ddr_page;
              else     rdata_a <= ddr_page;
            end
          end else begin
            wdog <= wdog + 16'd1;
            if (wdog + 16'd1 == TIMEOUT_W) begin
              // A stuck controller leaves the page state unknown, so force a full re-address.
              error      <= 1'b1;
              last_valid <= 1'b0;
              state      <= RESP;
              ack_a      <= ~sel;
              ack_b      <= sel;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_page_sequencer.sv
// Directed bench for ddr_page_sequencer: instruction streams, ack timing, arbitration, timeout, reset.
module tb_ddr_page_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, we_a, req_b, we_b;
  logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
  logic [31:0] ddr_page;
  logic        ddr_ready;

  logic        ack_a_m, ack_b_m, en_m, busy_m, err_m;
  logic [31:0] rdata_a_m, rdata_b_m;
  logic [11:0] inst_m;
  logic        ack_a_t, ack_b_t, en_t, busy_t, err_t;
  logic [31:0] rdata_a_t, rdata_b_t;
  logic [11:0] inst_t;

  bit          use16;
  logic        o_ack_a, o_ack_b, o_en, o_busy, o_err;
  logic [31:0] o_rdata_a, o_rdata_b;
  logic [11:0] o_inst;

  int tests = 0;
  int fails = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  ddr_page_sequencer dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .ack_a(ack_a_m), .rdata_a(rdata_a_m),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .ack_b(ack_b_m), .rdata_b(rdata_b_m),
    .ddr_inst(inst_m), .ddr_inst_en(en_m), .ddr_page(ddr_page), .ddr_ready(ddr_ready),
    .busy(busy_m), .error(err_m)
  );

  ddr_page_sequencer #(.TIMEOUT(16)) dut16 (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .ack_a(ack_a_t), .rdata_a(rdata_a_t),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .ack_b(ack_b_t), .rdata_b(rdata_b_t),
    .ddr_inst(inst_t), .ddr_inst_en(en_t), .ddr_page(ddr_page), .ddr_ready(ddr_ready),
    .busy(busy_t), .error(err_t)
  );

  always_comb begin
    o_ack_a   = use16 ? ack_a_t   : ack_a_m;
    o_ack_b   = use16 ? ack_b_t   : ack_b_m;
    o_en      = use16 ? en_t      : en_m;
    o_busy    = use16 ? busy_t    : busy_m;
    o_err     = use16 ? err_t     : err_m;
    o_rdata_a = use16 ? rdata_a_t : rdata_a_m;
    o_rdata_b = use16 ? rdata_b_t : rdata_b_m;
    o_inst    = use16 ? inst_t    : inst_m;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_la(input logic [31:0] a);
    for (int k = 0; k < 4; k++) exp_q.push_back({4'(1 + k), a[8*k +: 8]});
  endtask

  task automatic push_ld(input logic [31:0] d);
    for (int k = 0; k < 4; k++) exp_q.push_back({4'(5 + k), d[8*k +: 8]});
  endtask

  task automatic push_cmd(input bit we);
    exp_q.push_back({(we ? 4'd10 : 4'd9), 8'h00});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " inst"},  32'(o_inst), 32'h0);
    check({tag, " en"},    32'(o_en), 32'h0);
    check({tag, " ack_a"}, 32'(o_ack_a), 32'h0);
    check({tag, " ack_b"}, 32'(o_ack_b), 32'h0);
    check({tag, " rd_a"},  o_rdata_a, 32'h0);
    check({tag, " rd_b"},  o_rdata_b, 32'h0);
    check({tag, " busy"},  32'(o_busy), 32'h0);
    check({tag, " err"},   32'(o_err), 32'h0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = 32'h0; addr_b = 32'h0; wdata_a = 32'h0; wdata_b = 32'h0;
    ddr_ready = 1'b0; ddr_page = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs(tag);
    rst = 1'b0;
  endtask

  // delay: cycles after the command before ready rises (0 = already high, -1 = never)
  task automatic do_txn(input string tag, input bit sel, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int delay, input logic [31:0] page,
                        input int exp_lat);
    logic [11:0] got_q[$];
    bit          seen_cmd, got_ack, other_ack;
    int          k, lat;
    logic [31:0] rd;
    @(negedge clk);
    ddr_ready = 1'b1;
    ddr_page  = page;
    if (sel) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata; end
    else     begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata; end
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    seen_cmd = 1'b0; got_ack = 1'b0; other_ack = 1'b0; k = 0; lat = -1; rd = 32'h0;
    for (int i = 0; i < 200 && !got_ack; i++) begin
      if (o_en) got_q.push_back(o_inst);
      if (seen_cmd) k++;
      if (!seen_cmd && o_en && (o_inst[11:8] == 4'd9 || o_inst[11:8] == 4'd10)) begin
        seen_cmd  = 1'b1;
        k         = 0;
        ddr_ready = (delay == 0);
      end
      if (seen_cmd && delay > 0 && k == delay) ddr_ready = 1'b1;
      if (sel ? o_ack_b : o_ack_a) begin
        got_ack = 1'b1;
        lat     = k;
        rd      = sel ? o_rdata_b : o_rdata_a;
      end
      if (sel ? o_ack_a : o_ack_b) other_ack = 1'b1;
      if (!got_ack) @(negedge clk);
    end
    check({tag, " ninst"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size(); j++)
      if (j < got_q.size()) check($sformatf("%s inst%0d", tag, j), 32'(got_q[j]), 32'(exp_q[j]));
    check({tag, " ack"}, 32'(got_ack), 32'h1);
    check({tag, " lat"}, 32'(lat), 32'(exp_lat));
    check({tag, " other_ack"}, 32'(other_ack), 32'h0);
    if (!we) check({tag, " rdata"}, rd, page);
    $display("[TB] txn %s side=%s we=%0d addr=%h ninst=%0d ack_lat=%0d rdata=%h",
             tag, sel ? "b" : "a", we, addr, got_q.size(), lat, rd);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int   order[$];
    int   n;
    bit   hit_ld1;

    // Watchdog behaviour on the TIMEOUT=16 instance.
    use16 = 1'b1;
    do_reset("rst16");
    push_la(32'h0); push_ld(32'hDDCCBBAA); push_cmd(1'b1);
    do_txn("timeout_wr", 1'b0, 1'b1, 32'h0, 32'hDDCCBBAA, -1, 32'h0, 18);
    check("timeout err", 32'(o_err), 32'h1);
    push_la(32'h0); push_ld(32'h01020304); push_cmd(1'b1);
    do_txn("after_timeout_wr", 1'b0, 1'b1, 32'h0, 32'h01020304, 0, 32'h0, 3);
    check("err sticky", 32'(o_err), 32'h1);

    // Main instance.
    use16 = 1'b0;
    do_reset("rst");
    push_la(32'h0); push_ld(32'hDDCCBBAA); push_cmd(1'b1);
    do_txn("wr_a_miss", 1'b0, 1'b1, 32'h0, 32'hDDCCBBAA, 0, 32'h0, 3);
    push_cmd(1'b0);
    do_txn("rd_a_hit", 1'b0, 1'b0, 32'h0, 32'h0, 40, 32'h12345678, 41);
    push_la(32'h01000000); push_ld(32'h55667788); push_cmd(1'b1);
    do_txn("wr_b_bank", 1'b1, 1'b1, 32'h01000000, 32'h55667788, 0, 32'h0, 3);
    push_cmd(1'b0);
    do_txn("rd_b_hit", 1'b1, 1'b0, 32'h01000000, 32'h0, 0, 32'hCAFEF00D, 3);
    check("rd_a kept", o_rdata_a, 32'h12345678);
    check("err clear", 32'(o_err), 32'h0);

    // Round-robin with both requesters holding req high.
    do_reset("rst_arb");
    @(negedge clk);
    ddr_ready = 1'b1; ddr_page = 32'hA5A50001;
    req_a = 1'b1; we_a = 1'b0; addr_a = 32'h10;
    req_b = 1'b1; we_b = 1'b0; addr_b = 32'h20;
    n = 0;
    while (order.size() < 4 && n < 300) begin
      @(negedge clk);
      n++;
      if (o_ack_a) order.push_back(0);
      if (o_ack_b) order.push_back(1);
    end
    req_a = 1'b0; req_b = 1'b0;
    check("arb nacks", 32'(order.size()), 32'd4);
    for (int j = 0; j < order.size(); j++) check($sformatf("arb grant%0d", j), 32'(order[j]), 32'(j % 2));
    check("arb rd_b", o_rdata_b, 32'hA5A50001);
    $display("[TB] txn arbitration acks=%0d cycles=%0d", order.size(), n);

    // Reset during the DATA phase.
    do_reset("rst_mid");
    @(negedge clk);
    ddr_ready = 1'b1;
    req_a = 1'b1; we_a = 1'b1; addr_a = 32'h300; wdata_a = 32'h11223344;
    @(negedge clk);
    req_a = 1'b0;
    hit_ld1 = 1'b0;
    for (int i = 0; i < 30 && !hit_ld1; i++) begin
      if (o_en && o_inst[11:8] == 4'd6) hit_ld1 = 1'b1;
      else @(negedge clk);
    end
    check("mid reached DATA", 32'(hit_ld1), 32'h1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("mid_rst");
    @(negedge clk);
    check("mid no ack", 32'(o_ack_a), 32'h0);
    rst = 1'b0;
    $display("[TB] txn reset_during_data");
    push_la(32'h300); push_ld(32'h11223344); push_cmd(1'b1);
    do_txn("post_rst_wr", 1'b0, 1'b1, 32'h300, 32'h11223344, 0, 32'h0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ddr_page_sequencer.md
DDR_PAGE_SEQUENCER -- requirements
Module: ddr_page_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4096: max cycles to wait for ddr_ready after WRP/RDP before flagging error.
REQ-002 SHALL have parameters OP_NOP=0, OP_LA0..OP_LA3=1..4, OP_LD0..OP_LD3=5..8, OP_RDP=9, OP_WRP=10: 4-bit DdrCtl1 opcodes.
REQ-003 SHALL have ports: clock input 1 (sole clock); reset input 1 (asynchronous, active-high).
REQ-004 SHALL have ports, requester n in {a,b}: req_n input 1; we_n input 1 (1=write page, 0=read page); addr_n input 32; wdata_n input 32; ack_n output 1 (one-cycle completion pulse); rdata_n output 32 (read page, valid with ack_n).
REQ-005 SHALL have DdrCtl1-side ports: ddr_inst output 12 ({opcode[3:0], imm[7:0]}); ddr_inst_en output 1; ddr_page input 32; ddr_ready input 1.
REQ-006 SHALL have ports: busy output 1 (state != IDLE); error output 1 (sticky timeout flag).

Function
REQ-007 SHALL sequence page transactions over the DdrCtl1 instruction interface, issuing at most one instruction per cycle, sharing it between requesters a and b.
REQ-008 SHALL use states IDLE, ADDR, DATA, CMD, HOLD, WAIT, RESP.
REQ-009 IDLE: if ddr_ready=1 and any req_n=1, SHALL grant one requester, latch its we/addr/wdata, and leave IDLE next cycle; otherwise remain.
REQ-010 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; after reset, a has priority.
REQ-011 SHALL hold a last-address register plus valid bit; if the latched addr equals it and valid=1, go IDLE->DATA (write) or IDLE->CMD (read), skipping ADDR.
REQ-012 ADDR: four consecutive cycles issuing OP_LA0..OP_LA3 with imm=addr[8k+7:8k] for k=0..3; then DATA (write) or CMD (read); last address := addr, valid := 1.
REQ-013 DATA: four consecutive cycles issuing OP_LD0..OP_LD3 with imm=wdata[8k+7:8k]; then CMD.
REQ-014 CMD: one cycle issuing OP_WRP (write) or OP_RDP (read), imm=0; then HOLD.
REQ-015 HOLD: exactly one cycle, ddr_ready ignored; then WAIT.
REQ-016 WAIT: advance to RESP on the first cycle ddr_ready=1; on read, capture ddr_page into the granted requester's rdata that same cycle.
REQ-017 RESP: pulse ack of the granted requester for one cycle; return to IDLE.
REQ-018 ddr_inst_en SHALL be 1 exactly in ADDR, DATA and CMD cycles; otherwise ddr_inst={OP_NOP,8'h00}, ddr_inst_en=0.
REQ-019 Issue latency from grant, miss: write 9 instruction cycles, read 5; hit: write 5, read 1. ack SHALL follow the ddr_ready=1 cycle by one cycle.
REQ-020 A 16-bit watchdog SHALL clear on entering HOLD and increment in WAIT; if it reaches TIMEOUT, set error, invalidate last address, pulse ack with rdata unchanged, return to IDLE.
REQ-021 error SHALL clear only on reset; operation SHALL continue while error=1.
REQ-022 req_n deasserted mid-transaction SHALL not abort it; ack still pulses.
REQ-023 A requester holding req high after ack SHALL be arbitrated anew in IDLE, losing to a pending other requester.

Reset
REQ-024 Asynchronous reset SHALL force: IDLE, ddr_inst={OP_NOP,8'h00}, ddr_inst_en=0, ack_a=ack_b=0, rdata_a=rdata_b=0, busy=0, error=0, last-address valid=0, watchdog=0, round-robin pointer favouring a.
REQ-025 Reset mid-transaction SHALL abandon it with no ack; post-reset, the next access SHALL reissue all LA instructions.

Verification
REQ-026 Write a: addr=32'h00000000, wdata=32'hDDCCBBAA, ready=1 -> LA0..LA3 imm 00, LD0..LD3 imm AA,BB,CC,DD, WRP, one HOLD cycle, ack_a.
REQ-027 Read a same addr, ready low 40 cycles after RDP then ddr_page=32'h12345678 -> no LA issued, RDP only, rdata_a=32'h12345678 with ack_a.
REQ-028 a and b request same cycle, then both again -> grants b? no: a first (post-reset), then b; alternation continues.
REQ-029 Write b addr=32'h01000000 (bank change) -> LA3 imm=01 issued, last address updated, subsequent same-addr read skips ADDR.
REQ-030 TIMEOUT=16, ready held 0 after WRP -> ack after 16 WAIT cycles, error=1 sticky; next access reissues LA0..LA3.
REQ-031 Reset asserted during DATA -> all outputs at reset values immediately; no ack; ddr_inst_en=0.
